// File: rtl/ins_fetch_if.sv
// ins_fetch_if: control, instruction-memory and IR handshake bundle for ins_fetch.
interface ins_fetch_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              start;
   logic              stall;
   logic              jump;
   logic [ADDR_W-1:0] jump_addr;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              loadIR;
   logic [DATA_W-1:0] insout;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;
   modport master (
      output start, stall, jump, jump_addr, mem_ack, mem_rdata,
      input  mem_req, mem_addr, loadIR, insout, pc, busy, halted
   );
   modport slave (
      input  start, stall, jump, jump_addr, mem_ack, mem_rdata,
      output mem_req, mem_addr, loadIR, insout, pc, busy, halted
   );
endinterface

// File: rtl/ins_fetch.sv
// ins_fetch: single-outstanding instruction fetch FSM with jump redirect, stall and halt.
module ins_fetch #(
   parameter int                ADDR_W   = 12,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OP  = 4'hF
) (
   input logic       clk,
   input logic       rst_n,
   ins_fetch_if.slave bus
);
   typedef enum logic [2:0] {IDLE, REQ, LOAD, HOLD, HALT} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, ja_q, ja_d;
   logic [DATA_W-1:0] ins_q, ins_d;
   logic              jp_q, jp_d;
   logic              redirect;
   assign redirect = bus.jump | jp_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         ja_q  <= '0;
         ins_q <= '0;
         jp_q  <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ja_q  <= ja_d;
         ins_q <= ins_d;
         jp_q  <= jp_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.start ? REQ : IDLE;
         REQ:     state_d = (bus.mem_ack && !redirect) ? LOAD : REQ;
         LOAD:    state_d = (ins_q[DATA_W-1 -: 4] == HALT_OP) ? HALT : bus.stall ? HOLD : REQ;
         HOLD:    state_d = bus.stall ? HOLD : REQ;
         HALT:    state_d = bus.start ? REQ : HALT;
         default: state_d = IDLE;
      endcase
   end
   // A jump seen mid-request is parked until the ack retires the stale fetch.
   always_comb begin
      pc_d  = pc_q;
      ja_d  = ja_q;
      ins_d = ins_q;
      jp_d  = jp_q;
      if (state_q == REQ) begin
         if (bus.mem_ack && redirect) begin
            pc_d = bus.jump ? bus.jump_addr : ja_q;
            jp_d = 1'b0;
         end else if (bus.mem_ack) begin
            ins_d = bus.mem_rdata;
            pc_d  = pc_q + ADDR_W'(1);
         end else if (bus.jump) begin
            jp_d = 1'b1;
            ja_d = bus.jump_addr;
         end
      end else if (bus.jump) begin
         pc_d = bus.jump_addr;
      end
   end
   always_comb begin
      bus.mem_req  = state_q == REQ;
      bus.mem_addr = pc_q;
      bus.loadIR   = state_q == LOAD;
      bus.insout   = ins_q;
      bus.pc       = pc_q;
      bus.busy     = state_q == REQ || state_q == LOAD || state_q == HOLD;
      bus.halted   = state_q == HALT;
   end
endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: randomized fetch traffic checked by a spec-level model through a scoreboard.
module tb_ins_fetch;
   localparam int AW = 12;
   localparam int DW = 16;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   ins_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   ins_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'h000), .HALT_OP(4'hF)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   typedef struct packed {
      logic          req;
      logic [AW-1:0] addr;
      logic          ld;
      logic [DW-1:0] ins;
      logic [AW-1:0] pc;
      logic          busy;
      logic          halted;
   } st_t;
   typedef enum {S_IDLE, S_REQ, S_LOAD, S_HOLD, S_HALT} ms_t;
   st_t               st_q[$];
   logic [DW+AW-1:0]  ld_q[$];
   logic [DW-1:0]     mem [4096];
   int                total = 0, bad = 0;
   bit                active = 0;
   ms_t               m_st;
   int                m_pc, m_ja;
   logic [DW-1:0]     m_ins;
   bit                m_jp;
   st_t               e;
   logic [DW+AW-1:0]  le;
   int                resets = 0;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h @%0t", n, a, x, $time);
      end
   endtask
   // Fetch rules applied to one rising edge; expected outputs go to the scoreboard.
   task automatic step(input bit rn);
      if (!rn) begin
         m_st = S_IDLE; m_pc = 0; m_ins = '0; m_jp = 0;
      end else begin
         case (m_st)
            S_IDLE: begin
               if (bus.jump) m_pc = bus.jump_addr;
               if (bus.start) m_st = S_REQ;
            end
            S_REQ: begin
               if (bus.mem_ack) begin
                  if (bus.jump || m_jp) begin
                     m_pc = bus.jump ? int'(bus.jump_addr) : m_ja;
                     m_jp = 0;
                  end else begin
                     m_ins = mem[m_pc];
                     m_pc  = (m_pc + 1) % 4096;
                     m_st  = S_LOAD;
                     ld_q.push_back({m_ins, AW'(m_pc)});
                  end
               end else if (bus.jump) begin
                  m_jp = 1; m_ja = bus.jump_addr;
               end
            end
            S_LOAD: begin
               if (bus.jump) m_pc = bus.jump_addr;
               m_st = (m_ins[15:12] == 4'hF) ? S_HALT : bus.stall ? S_HOLD : S_REQ;
            end
            S_HOLD: begin
               if (bus.jump) m_pc = bus.jump_addr;
               if (!bus.stall) m_st = S_REQ;
            end
            default: begin
               if (bus.jump) m_pc = bus.jump_addr;
               if (bus.start) m_st = S_REQ;
            end
         endcase
      end
      st_q.push_back('{req: m_st == S_REQ, addr: AW'(m_pc), ld: m_st == S_LOAD, ins: m_ins,
                       pc: AW'(m_pc), busy: m_st inside {S_REQ, S_LOAD, S_HOLD},
                       halted: m_st == S_HALT});
   endtask
   initial forever begin
      @(posedge clk);
      #1;
      if (active && st_q.size() > 0) begin
         e = st_q.pop_front();
         chk("mem_req", 64'(bus.mem_req), 64'(e.req));
         chk("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
         chk("loadIR", 64'(bus.loadIR), 64'(e.ld));
         chk("insout", 64'(bus.insout), 64'(e.ins));
         chk("pc", 64'(bus.pc), 64'(e.pc));
         chk("busy", 64'(bus.busy), 64'(e.busy));
         chk("halted", 64'(bus.halted), 64'(e.halted));
      end
      if (active && bus.loadIR === 1'b1) begin
         if (ld_q.size() == 0) begin
            total++; bad++;
            $display("FAIL load_unexpected act=%0h exp=none @%0t", bus.insout, $time);
         end else begin
            le = ld_q.pop_front();
            chk("load_word", 64'(bus.insout), 64'(le[DW+AW-1:AW]));
            chk("load_pc", 64'(bus.pc), 64'(le[AW-1:0]));
         end
      end
   end
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
      mem[0] = 16'h1003;
      mem[1] = 16'h2004;
      bus.start = 0; bus.stall = 0; bus.jump = 0; bus.jump_addr = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mem_req", 64'(bus.mem_req), 0);
      chk("rst_pc", 64'(bus.pc), 0);
      chk("rst_insout", 64'(bus.insout), 0);
      chk("rst_loadIR", 64'(bus.loadIR), 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_halted", 64'(bus.halted), 0);
      m_st = S_IDLE; m_pc = 0; m_ins = '0; m_jp = 0; m_ja = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      active = 1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         if (i < 4) begin
            bus.start = (i == 0); bus.mem_ack = 1; bus.stall = 0; bus.jump = 0;
         end else begin
            bus.start   = $urandom_range(0, 3) == 0;
            bus.stall   = $urandom_range(0, 2) == 0;
            bus.jump    = $urandom_range(0, 11) == 0;
            bus.mem_ack = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
               0: bus.jump_addr = 12'h0A0;
               1: bus.jump_addr = 12'hFFF;
               2: bus.jump_addr = 12'h005;
               default: bus.jump_addr = AW'($urandom);
            endcase
         end
         bus.mem_rdata = mem[m_pc];
         if (i > 4 && m_st == S_REQ && $urandom_range(0, 59) == 0) begin
            bus.mem_ack = 1;
            rst_n = 1'b0;
            resets++;
            #2;
            chk("arst_mem_req", 64'(bus.mem_req), 0);
            chk("arst_loadIR", 64'(bus.loadIR), 0);
            chk("arst_busy", 64'(bus.busy), 0);
            chk("arst_pc", 64'(bus.pc), 0);
            chk("arst_insout", 64'(bus.insout), 0);
         end
         step(rst_n);
      end
      @(negedge clk);
      active = 0;
      chk("load_queue_empty", 64'(ld_q.size()), 0);
      chk("status_queue_empty", 64'(st_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
